// File: rtl/fp_accumulator.sv
// -----------------------------------------------------------------------------
// fp_accumulator
//   Streaming front-end for a combinational single-precision adder. It takes a
//   valid/ready stream of IEEE-754 single operands and keeps a running sum. The
//   accumulator register drives adder input a, and the incoming beat drives
//   adder input b. It emits one sum per packet, and in_last marks the end of a
//   packet.
//
// Ports
//   clk        in   1      clock, all state updates on posedge
//   rst        in   1      synchronous active-high reset (beats clear)
//   clear      in   1      synchronous abort of the current packet
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block can accept a beat (low only while a sum waits)
//   in_data    in   XLEN   operand, IEEE-754 single
//   in_last    in   1      beat is the final element of its packet
//   out_valid  out  1      packet sum valid
//   out_ready  in   1      downstream accepts the sum
//   out_data   out  XLEN   packet sum, IEEE-754 single
//   out_count  out  CNT_W  elements summed in the packet (saturating)
//   out_exc    out  1      sticky Inf/NaN/overflow flag for the packet
//
// Configuration
//   FP_ACC_EXC_FLAG_EN : when defined, out_exc tracks exponent-field 8'hFF on
//   any loaded or summed value. When undefined, out_exc is tied low and no
//   exponent-check logic is built.
//
// Also contains fp_adder: a combinational single-precision adder with
// round-to-nearest-even. It supports subnormals and produces a quiet NaN for
// NaN inputs or for Inf-Inf.
// -----------------------------------------------------------------------------

module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic        swap, found, roundUp;
  logic        aNan, bNan, aInf, bInf;
  logic [31:0] bigOp, smallOp;
  logic [7:0]  expBig, expSmall, shiftAmt;
  logic [26:0] mantBig, mantSmall, aligned, norm;
  logic [27:0] sum;
  logic [9:0]  expWork, expFinal;
  logic [4:0]  lzCnt;
  logic [24:0] rounded;
  logic [22:0] fracOut;

  always_comb begin
    aNan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bNan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    aInf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    bInf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    // Order operands by magnitude so that the subtraction below never goes
    // negative. The result sign is then always the sign of the larger operand.
    swap    = b[30:0] > a[30:0];
    bigOp   = swap ? b : a;
    smallOp = swap ? a : b;

    // Subnormals use an effective exponent of 1 and have no hidden bit.
    // Three extra low bits hold guard/round/sticky.
    expBig    = (bigOp[30:23] == 8'd0) ? 8'd1 : bigOp[30:23];
    expSmall  = (smallOp[30:23] == 8'd0) ? 8'd1 : smallOp[30:23];
    mantBig   = {(bigOp[30:23] != 8'd0), bigOp[22:0], 3'b000};
    mantSmall = {(smallOp[30:23] != 8'd0), smallOp[22:0], 3'b000};
    shiftAmt  = expBig - expSmall;

    // Align the smaller operand. Bits shifted out fold into the sticky LSB.
    if (shiftAmt >= 8'd27) begin
      aligned = {26'd0, |mantSmall};
    end else begin
      aligned    = mantSmall >> shiftAmt;
      aligned[0] = aligned[0] | (|(mantSmall & ((27'd1 << shiftAmt) - 27'd1)));
    end

    if (bigOp[31] == smallOp[31]) sum = {1'b0, mantBig} + {1'b0, aligned};
    else                          sum = {1'b0, mantBig} - {1'b0, aligned};

    // Normalise. A carry shifts right by one. Otherwise, shift left to bring
    // the leading one to bit 26, but never let the exponent drop below 1.
    // Results that still lack a leading one become subnormals.
    expWork = {2'b00, expBig};
    norm    = sum[26:0];
    lzCnt   = 5'd0;
    found   = 1'b0;
    if (sum[27]) begin
      norm    = {sum[27:2], sum[1] | sum[0]};
      expWork = expWork + 10'd1;
    end else begin
      lzCnt = 5'd27;
      for (int i = 26; i >= 0; i--) begin
        if (!found && norm[i]) begin
          lzCnt = 5'(26 - i);
          found = 1'b1;
        end
      end
      if ({5'd0, lzCnt} > (expWork - 10'd1)) lzCnt = 5'(expWork - 10'd1);
      norm    = norm << lzCnt;
      expWork = expWork - {5'd0, lzCnt};
    end

    // Round to nearest, ties to even. A carry out of the mantissa bumps the
    // exponent, and a subnormal that rounds up to bit 23 becomes normal.
    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
    rounded = {1'b0, norm[26:3]} + {24'd0, roundUp};
    if (rounded[24])      expFinal = expWork + 10'd1;
    else if (rounded[23]) expFinal = expWork;
    else                  expFinal = 10'd0;
    fracOut = rounded[24] ? rounded[23:1] : rounded[22:0];

    if (aNan || bNan || (aInf && bInf && (a[31] != b[31]))) begin
      result = 32'h7FC0_0000;
    end else if (aInf || bInf) begin
      result = {bigOp[31], 8'hFF, 23'd0};
    end else if (sum == 28'd0) begin
      result = {bigOp[31] & smallOp[31], 31'd0};
    end else if (expFinal >= 10'd255) begin
      result = {bigOp[31], 8'hFF, 23'd0};
    end else begin
      result = {bigOp[31], expFinal[7:0], fracOut};
    end
  end

endmodule

module fp_accumulator #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_exc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           stateQ, stateD;
  logic [XLEN-1:0]  accQ, accD;
  logic [CNT_W-1:0] countQ, countD;
  logic [XLEN-1:0]  sumResult;
  logic             beat;

  fp_adder uAdder (
    .a      (accQ),
    .b      (in_data),
    .result (sumResult)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
      accQ   <= '0;
      countQ <= '0;
    end else begin
      stateQ <= stateD;
      accQ   <= accD;
      countQ <= countD;
    end
  end

  // The first element of a packet is loaded directly rather than added to
  // zero, so a lone -0.0 or a NaN payload passes through unchanged.
  always_comb begin
    stateD    = stateQ;
    accD      = accQ;
    countD    = countQ;
    in_ready  = (stateQ != DONE);
    out_valid = (stateQ == DONE);
    beat      = in_valid && in_ready;

    if (clear) begin
      stateD = IDLE;
      accD   = '0;
      countD = '0;
    end else begin
      case (stateQ)
        IDLE: begin
          if (beat) begin
            accD   = in_data;
            countD = CNT_W'(1);
            stateD = in_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            accD   = sumResult;
            countD = (&countQ) ? countQ : countQ + CNT_W'(1);
            stateD = in_last ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) stateD = IDLE;
        end
        default: stateD = IDLE;
      endcase
    end
  end

  assign out_data  = accQ;
  assign out_count = countQ;

`ifdef FP_ACC_EXC_FLAG_EN
  logic excQ, excD;

  always_ff @(posedge clk) begin
    if (rst) excQ <= 1'b0;
    else     excQ <= excD;
  end

  // The flag is sticky for the packet. It is cleared on the way back to IDLE.
  always_comb begin
    excD = excQ;
    if (clear) begin
      excD = 1'b0;
    end else begin
      case (stateQ)
        IDLE:    if (beat) excD = (in_data[30:23] == 8'hFF);
        ACCUM:   if (beat) excD = excQ | (in_data[30:23] == 8'hFF) |
                                  (sumResult[30:23] == 8'hFF);
        DONE:    if (out_ready) excD = 1'b0;
        default: excD = 1'b0;
      endcase
    end
  end

  assign out_exc = excQ;
`else
  assign out_exc = 1'b0;
`endif

endmodule

// File: tb/tb_fp_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fp_accumulator
//   Directed vectors with hand-computed IEEE-754 sums for fp_accumulator.
//   Inputs are driven 1 time unit after a rising edge, and outputs are sampled
//   at that same point.
// -----------------------------------------------------------------------------

module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst, clear, inValid, inLast, outReady;
  logic [31:0] inData;
  logic        inReady, outValid, outExc;
  logic [31:0] outData;
  logic [15:0] outCount;

  int checks = 0;
  int errors = 0;
  int waits;
  logic expExc;

  fp_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .in_last   (inLast),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .out_count (outCount),
    .out_exc   (outExc)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one beat and waits, within a bounded number of cycles, until it is
  // taken. in_valid is left high so that a caller can stream beats back to
  // back. The number of cycles spent waiting is returned.
  task automatic applyStimulus(input logic [31:0] data, input logic last,
                               output int waitCycles);
    inValid    = 1'b1;
    inData     = data;
    inLast     = last;
    waitCycles = 0;
    while (!inReady && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    if (!inReady) checkOutput("in_ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic dropInput();
    inValid = 1'b0;
    inLast  = 1'b0;
    inData  = 32'd0;
  endtask

  task automatic acceptSum();
    outReady = 1'b1;
    tick();
    checkOutput("valid_after_accept", {31'd0, outValid}, 32'd0);
    outReady = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; outReady = 1'b0;
    dropInput();
    tick(); tick();
    rst = 1'b0;
    checkOutput("reset_valid", {31'd0, outValid}, 32'd0);
    checkOutput("reset_data",  outData, 32'd0);
    checkOutput("reset_count", {16'd0, outCount}, 32'd0);
    checkOutput("reset_exc",   {31'd0, outExc}, 32'd0);
    checkOutput("reset_ready", {31'd0, inReady}, 32'd1);

    // 1.0 + 2.0 + 3.0 = 6.0; out_valid is high right after the last beat.
    applyStimulus(32'h3F800000, 1'b0, waits);
    applyStimulus(32'h40000000, 1'b0, waits);
    applyStimulus(32'h40400000, 1'b1, waits);
    dropInput();
    checkOutput("p1_valid", {31'd0, outValid}, 32'd1);
    checkOutput("p1_ready", {31'd0, inReady}, 32'd0);
    checkOutput("p1_data",  outData, 32'h40C00000);
    checkOutput("p1_count", {16'd0, outCount}, 32'd3);
    acceptSum();

    // A single beat passes through unchanged.
    applyStimulus(32'h40490FDB, 1'b1, waits);
    dropInput();
    checkOutput("p2_valid", {31'd0, outValid}, 32'd1);
    checkOutput("p2_data",  outData, 32'h40490FDB);
    checkOutput("p2_count", {16'd0, outCount}, 32'd1);
    acceptSum();

    // 1.5 + (-0.5) = 1.0, held under back-pressure while another beat waits.
    applyStimulus(32'h3FC00000, 1'b0, waits);
    applyStimulus(32'hBF000000, 1'b1, waits);
    inValid = 1'b1; inData = 32'h3F800000; inLast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("p3_hold_data",  outData, 32'h3F800000);
      checkOutput("p3_hold_ready", {31'd0, inReady}, 32'd0);
      checkOutput("p3_hold_valid", {31'd0, outValid}, 32'd1);
      tick();
    end
    dropInput();
    checkOutput("p3_count", {16'd0, outCount}, 32'd2);
    acceptSum();
    tick();
    checkOutput("p3_single_transfer", {31'd0, outValid}, 32'd0);

    // Clear after two beats of a four-beat packet, while a beat is offered.
    applyStimulus(32'h3F800000, 1'b0, waits);
    applyStimulus(32'h3F800000, 1'b0, waits);
    inValid = 1'b1; inData = 32'h3F800000; inLast = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    dropInput();
    checkOutput("clr_count", {16'd0, outCount}, 32'd0);
    checkOutput("clr_data",  outData, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("clr_no_valid", {31'd0, outValid}, 32'd0);
      tick();
    end
    applyStimulus(32'h40000000, 1'b0, waits);
    applyStimulus(32'h40000000, 1'b1, waits);
    dropInput();
    checkOutput("clr_next_data",  outData, 32'h40800000);
    checkOutput("clr_next_count", {16'd0, outCount}, 32'd2);
    acceptSum();

    // Back-to-back packets with in_valid held high: one bubble between them.
    outReady = 1'b1;
    applyStimulus(32'h3F800000, 1'b0, waits);
    applyStimulus(32'h40000000, 1'b1, waits);
    checkOutput("b2b_a_data",  outData, 32'h40400000);
    checkOutput("b2b_a_count", {16'd0, outCount}, 32'd2);
    applyStimulus(32'h40800000, 1'b0, waits);
    checkOutput("b2b_bubble", waits, 32'd1);
    applyStimulus(32'h3F000000, 1'b1, waits);
    checkOutput("b2b_b_wait", waits, 32'd0);
    dropInput();
    checkOutput("b2b_b_data",  outData, 32'h40900000);
    checkOutput("b2b_b_count", {16'd0, outCount}, 32'd2);
    tick();
    checkOutput("b2b_b_done", {31'd0, outValid}, 32'd0);
    outReady = 1'b0;

    // Exception flag: Inf + 1.0 = Inf; the next finite packet starts clean.
`ifdef FP_ACC_EXC_FLAG_EN
    expExc = 1'b1;
`else
    expExc = 1'b0;
`endif
    applyStimulus(32'h7F800000, 1'b0, waits);
    applyStimulus(32'h3F800000, 1'b1, waits);
    dropInput();
    checkOutput("exc_data", outData, 32'h7F800000);
    checkOutput("exc_flag", {31'd0, outExc}, {31'd0, expExc});
    acceptSum();
    applyStimulus(32'h3F800000, 1'b0, waits);
    applyStimulus(32'h3F800000, 1'b1, waits);
    dropInput();
    checkOutput("exc_clean_data", outData, 32'h40000000);
    checkOutput("exc_clean_flag", {31'd0, outExc}, 32'd0);
    acceptSum();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
